ps2_scancode_rx: RTL and testbench

PS/2 serial front end that sits directly upstream of the keyboard key-tracking block, the one that produces the key1..key4 codes, priorities, Shooting and Jumping.
- Synchronises and glitch-filters raw psClk/psData.
- Deserialises 11-bit device-to-host frames and checks start, odd parity and stop bits.
- Folds the E0/F0 prefix bytes into flags.
- Emits one single-cycle-valid scan code per key event.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_clk_filter.sv | 69 ++++++
 rtl/ps2_scancode_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Holds the frame FSM states, the prefix bytes and a parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [2:0] PS2_LAST_BIT  = 3'(PS2_DATA_BITS - 1);

    // Odd parity: data byte plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line synchronisers, psClk glitch filter and falling-edge strobe.
// The filtered level only moves after FILTER_LEN consecutive differing samples.
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic psClk,
    input  logic psData,
    output logic dataSync,
    output logic clkFilt,
    output logic fall
);

    localparam int             CW   = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   filt_q;
    logic                   filt_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   clk_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], psClk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], psData};
        cnt_d       = cnt_q;
        filt_d      = filt_q;
        if (clk_s == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            filt_d = ~filt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            cnt_q       <= '0;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            fall_q      <= fall_d;
        end
    end

    assign dataSync = data_sync_q[SYNC_STAGES-1];
    assign clkFilt  = filt_q;
    assign fall     = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver folding E0/F0 prefixes into flags.
// Define PS2_ERR_COUNT_EN to add the saturating errCount output.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       psClk,
    input  logic       psData,
    output logic [7:0] scanCode,
    output logic       scanValid,
    output logic       isBreak,
    output logic       isExtended,
    output logic       parityErr,
    output logic       frameErr,
    output logic       busy
`ifdef PS2_ERR_COUNT_EN
    ,
    output logic [7:0] errCount
`endif
);

    localparam int            WW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

    logic data_s;
    logic clk_filt;
    logic fall;

    ps2_clk_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .Clk     (Clk),
        .Reset   (Reset),
        .psClk   (psClk),
        .psData  (psData),
        .dataSync(data_s),
        .clkFilt (clk_filt),
        .fall    (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          is_break_q, is_break_d;
    logic          is_ext_q, is_ext_d;
    logic          scan_valid_q, scan_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout;

    assign timeout = (state_q != IDLE) && (wd_q == WD_MAX);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        scan_code_d  = scan_code_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        scan_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || fall || timeout) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        // A timeout wins over a fall arriving on the same cycle.
        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == PS2_LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end else if (!ps2_parity_ok(shreg_q, par_q)) begin
                        parity_err_d = 1'b1;
                        ext_pend_d   = 1'b0;
                        brk_pend_d   = 1'b0;
                    end else if (shreg_q == PS2_PREFIX_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shreg_q == PS2_PREFIX_BREAK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        scan_code_d  = shreg_q;
                        is_break_d   = brk_pend_q;
                        is_ext_d     = ext_pend_q;
                        scan_valid_d = 1'b1;
                        ext_pend_d   = 1'b0;
                        brk_pend_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            wd_q         <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            scan_code_q  <= '0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            scan_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            wd_q         <= wd_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            scan_code_q  <= scan_code_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            scan_valid_q <= scan_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign scanCode   = scan_code_q;
    assign scanValid  = scan_valid_q;
    assign isBreak    = is_break_q;
    assign isExtended = is_ext_q;
    assign parityErr  = parity_err_q;
    assign frameErr   = frame_err_q;
    assign busy       = (state_q != IDLE);

`ifdef PS2_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((parity_err_q || frame_err_q) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign errCount = err_cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = clk_filt;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx with a shortened bit period
// and watchdog so the whole run stays within a small cycle budget.
module tb_ps2_scancode_rx;

    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic       Clk;
    logic       Reset;
    logic       psClk;
    logic       psData;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       isBreak;
    logic       isExtended;
    logic       parityErr;
    logic       frameErr;
    logic       busy;
`ifdef PS2_ERR_COUNT_EN
    logic [7:0] errCount;
`endif

    ps2_scancode_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .psClk     (psClk),
        .psData    (psData),
        .scanCode  (scanCode),
        .scanValid (scanValid),
        .isBreak   (isBreak),
        .isExtended(isExtended),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .busy      (busy)
`ifdef PS2_ERR_COUNT_EN
        ,
        .errCount  (errCount)
`endif
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_PAR   = 2'd1;
    localparam logic [1:0] K_FRAME = 2'd2;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    logic [7:0] m_code;
    logic       m_brk;
    logic       m_ext;
    logic       m_bpend;
    logic       m_epend;
    int         m_err;

    task automatic push(input logic [1:0] k);
        ev_t e;
        e.kind = k;
        e.code = m_code;
        e.brk  = m_brk;
        e.ext  = m_ext;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_code  = 8'h00;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
        m_bpend = 1'b0;
        m_epend = 1'b0;
        m_err   = 0;
        exp_q.delete();
    endtask

    task automatic model_err(input logic [1:0] k);
        m_bpend = 1'b0;
        m_epend = 1'b0;
        if (m_err < 255) m_err++;
        push(k);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic par_ok,
                               input logic stop_ok);
        if (!stop_ok) begin
            model_err(K_FRAME);
        end else if (!par_ok) begin
            model_err(K_PAR);
        end else if (b == 8'hE0) begin
            m_epend = 1'b1;
        end else if (b == 8'hF0) begin
            m_bpend = 1'b1;
        end else begin
            m_code  = b;
            m_brk   = m_bpend;
            m_ext   = m_epend;
            m_bpend = 1'b0;
            m_epend = 1'b0;
            push(K_VALID);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                             input logic flip,
                                             input logic bad_stop);
        return {~bad_stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            psData = f[i];
            wait_clk(HALF / 2);
            psClk = 1'b0;
            wait_clk(HALF);
            psClk = 1'b1;
            wait_clk(HALF / 2);
        end
        psData = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_clk(1);
            n++;
        end
        wait_clk(4);
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip,
                              input logic bad_stop);
        model_frame(b, ~flip, ~bad_stop);
        send_bits(mk_frame(b, flip, bad_stop), 0, 11);
        drain($sformatf("frame_%h", b), 200);
    endtask

    always @(negedge Clk) begin
        if (!Reset && (scanValid || parityErr || frameErr)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_pulse: v/p/f=%b%b%b code=%h, required no pulse",
                         scanValid, parityErr, frameErr, scanCode);
            end else begin
                mon_e = exp_q.pop_front();
                if ({scanValid, parityErr, frameErr} !==
                        {mon_e.kind == K_VALID, mon_e.kind == K_PAR,
                         mon_e.kind == K_FRAME} ||
                    scanCode !== mon_e.code || isBreak !== mon_e.brk ||
                    isExtended !== mon_e.ext) begin
                    n_fail++;
                    $display("FAIL event: v/p/f=%b%b%b code=%h brk=%b ext=%b, required kind=%0d code=%h brk=%b ext=%b",
                             scanValid, parityErr, frameErr, scanCode, isBreak,
                             isExtended, mon_e.kind, mon_e.code, mon_e.brk, mon_e.ext);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_checks++;
        if ({scanCode, scanValid, isBreak, isExtended, parityErr, frameErr, busy}
                !== 14'd0) begin
            n_fail++;
            $display("FAIL %s: code=%h v=%b b=%b e=%b p=%b f=%b busy=%b, required all 0",
                     name, scanCode, scanValid, isBreak, isExtended, parityErr,
                     frameErr, busy);
        end
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        psClk  = 1'b1;
        psData = 1'b1;
        model_reset();
        wait_clk(5);
        check_zero("reset_state");
        Reset = 1'b0;
        wait_clk(10);
        check_zero("after_reset");
    endtask

    task automatic test_make();
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 0, 5);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_busy: busy=%b, required 1", busy);
        end
        model_err(K_FRAME);
        drain("timeout", TMO + 200);
        send_frame(8'h29, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        logic [10:0] f;
        psClk = 1'b0;
        wait_clk(3);
        psClk = 1'b1;
        wait_clk(30);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_glitch: busy=%b, required 0", busy);
        end
        f = mk_frame(8'h1C, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b1, 1'b1);
        send_bits(f, 0, 4);
        psData = f[4];
        psClk  = 1'b0;
        wait_clk(3);
        psClk = 1'b1;
        wait_clk(30);
        send_bits(f, 4, 11);
        drain("glitch_frame", 200);
    endtask

    task automatic test_reset_midframe();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 6);
        Reset = 1'b1;
        model_reset();
        #1;
        check_zero("midframe_reset");
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(5);
        check_zero("midframe_after");
        send_frame(8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_err_count();
`ifdef PS2_ERR_COUNT_EN
        n_checks++;
        if (errCount !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL err_count: got=%0d, required %0d", errCount, m_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_errors();
        test_err_count();
        test_timeout();
        test_err_count();
        test_glitch();
        test_reset_midframe();
        test_err_count();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
